health_resolver: RTL and testbench
==================================

Name: health_resolver

Overview:
- Game-side counterpart to the per-player state block: consumes landed-hit requests, shield levels and shielding status for both players, and owns both players' health.
- Applies damage, invulnerability frames, KO detection and the round-restart sequence.
- Runs on the 2 Hz shield tick.
- Health outputs feed back into each player block and the HUD/sprite renderer.

Parameters:
MAX_HEALTH, 15, health loaded at reset/round start (4-bit)
PUNCH_DAMAGE, 3, damage for an unshielded hit
CHIP_DAMAGE, 1, damage for a shielded hit
SHIELD_MIN, 1, minimum shield level for shielding to count
IFRAME_TICKS, 2, slow ticks of invulnerability after a damaging hit
KO_HOLD_TICKS, 6, slow ticks held in KO before restart is accepted

Ports:
slowed_shield_clk  in  1  2 Hz tick clock
reset  in  1  synchronous, active-low
p0_hit_req  in  1  level request: a hit landed on player 0; held until p0 ack seen
p1_hit_req  in  1  same for player 1
p0_shielding  in  1  player 0 action is SHIELDING
p1_shielding  in  1  player 1 action is SHIELDING
p0_shield  in  4  player 0 shield level
p1_shield  in  4  player 1 shield level
round_restart  in  1  level; starts a new round from KO
hit_ack  out  2  [0]=p0 hit consumed, [1]=p1 hit consumed
p0_health  out  4  player 0 health
p1_health  out  4  player 1 health
iframe_active  out  2  per-player invulnerability (sprite blink)
game_over  out  1  round ended
winner  out  1  surviving player index; valid when game_over && !draw
draw  out  1  both KO'd on the same tick

Behaviour:
- Reset (reset==0 at edge), from any state:
  - healths = MAX_HEALTH; hit_ack = 0; iframe counters = 0; synchronizer flops = 0; KO counter = 0.
  - game_over = winner = draw = 0; state = FIGHT.
- Request synchronization: each hit_req passes through 2 flops → req_s[i].
- 4-phase handshake per player:
  - req_s[i]=1 && hit_ack[i]=0: hit consumed on that edge and hit_ack[i] set.
  - hit_ack[i] held while req_s[i]=1; cleared on the first edge with req_s[i]=0.
  - Exactly one hit per request high-period.
- Latency: health and ack update on the 3rd rising edge after the req is sampled high.
- Damage (FIGHT only):
  - d = CHIP_DAMAGE if shielding && shield >= SHIELD_MIN, else PUNCH_DAMAGE.
  - If iframe counter[i] != 0: d = 0, but the hit is still acked.
  - health = health - d, saturating at 0.
  - If d != 0, iframe counter loads IFRAME_TICKS.
- iframe counters decrement by 1 per tick when nonzero. A hit on the tick the counter reaches 0 uses the pre-decrement value, so it is blocked.
- iframe_active[i] = (counter[i] != 0).
- Simultaneous hits on both players in one tick: processed independently in the same edge.
- FSM:
  - FIGHT → KO on the edge where either updated health == 0:
    - only one player 0: game_over=1, winner = other player, draw=0.
    - both 0: game_over=1, draw=1, winner=0.
    - KO counter loads KO_HOLD_TICKS.
  - KO:
    - Counter decrements to 0.
    - Requests are still acked, with no damage (prevents requester deadlock).
    - Healths frozen; round_restart ignored while counter != 0.
  - KO → FIGHT on the edge with counter == 0 && round_restart == 1:
    - healths = MAX_HEALTH; iframes = 0; game_over = winner = draw = 0.
    - Pending acks follow normal handshake rules.
  - round_restart in FIGHT: ignored.
- Widths: all health arithmetic is 4-bit with saturation; no wrap below 0. MAX_HEALTH ≤ 15.

Test Plan:
- Reset then p1_hit_req high, p1_shielding=0 → on 3rd edge p1_health 15→12, hit_ack[1]=1, iframe_active[1]=1. Drop req → ack clears 3 edges later.
- p0_shielding=1, p0_shield=4, hit → p0_health 15→14. Repeat with p0_shield=0 after iframes expire → 14→11.
- Second p1 request issued while iframe counter=2 → acked, p1_health unchanged. After 2 ticks with no hit, a new request deals 3.
- p0 at health 2, p1 at 3, both hit same tick → both saturate to 0, game_over=1, draw=1, state KO.
- In KO with round_restart=1 held: no change for 6 ticks; on the following edge healths=15, game_over=0. A hit req during KO is acked with no damage.
- Reset asserted mid-KO with hit_ack[0]=1 → next edge: all outputs at reset values, state FIGHT.

Source files
------------

// File: rtl/health_resolver.sv
// Owns both players' health: synchronizes landed-hit requests, applies damage
// with invulnerability frames, detects KO and runs the round-restart hold.
module health_resolver #(
  parameter int unsigned MAX_HEALTH    = 15,
  parameter int unsigned PUNCH_DAMAGE  = 3,
  parameter int unsigned CHIP_DAMAGE   = 1,
  parameter int unsigned SHIELD_MIN    = 1,
  parameter int unsigned IFRAME_TICKS  = 2,
  parameter int unsigned KO_HOLD_TICKS = 6
) (
  input  logic       slowed_shield_clk,
  input  logic       reset,
  input  logic       p0_hit_req,
  input  logic       p1_hit_req,
  input  logic       p0_shielding,
  input  logic       p1_shielding,
  input  logic [3:0] p0_shield,
  input  logic [3:0] p1_shield,
  input  logic       round_restart,
  output logic [1:0] hit_ack,
  output logic [3:0] p0_health,
  output logic [3:0] p1_health,
  output logic [1:0] iframe_active,
  output logic       game_over,
  output logic       winner,
  output logic       draw
);

  localparam int unsigned HW  = 4;
  localparam int unsigned IFW = (IFRAME_TICKS < 1) ? 1 : $clog2(IFRAME_TICKS + 1);
  localparam int unsigned KOW = (KO_HOLD_TICKS < 1) ? 1 : $clog2(KO_HOLD_TICKS + 1);

  typedef enum logic {
    FIGHT = 1'b0,
    KO    = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             sync1_q, req_s_q;
  logic [1:0]             ack_q, ack_d;
  logic [1:0][HW-1:0]     health_q, health_d;
  logic [1:0][IFW-1:0]    iframe_q, iframe_d;
  logic [1:0]             iframe_act_q;
  logic [KOW-1:0]         ko_cnt_q, ko_cnt_d;
  logic                   game_over_q, game_over_d;
  logic                   winner_q, winner_d;
  logic                   draw_q, draw_d;

  logic [1:0]             shielding_w;
  logic [1:0][HW-1:0]     shield_w;
  logic [1:0]             hit_take;

  assign shielding_w = {p1_shielding, p0_shielding};
  assign shield_w    = {p1_shield, p0_shield};
  // A hit is consumed on the first synchronized-high edge of each request.
  assign hit_take    = req_s_q & ~ack_q;

  function automatic logic [HW-1:0] hit_damage(input logic shielding,
                                               input logic [HW-1:0] level);
    if (shielding && (level >= HW'(SHIELD_MIN))) begin
      return HW'(CHIP_DAMAGE);
    end
    return HW'(PUNCH_DAMAGE);
  endfunction

  function automatic logic [HW-1:0] sat_sub(input logic [HW-1:0] a,
                                            input logic [HW-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  // Next-state: handshake, damage, iframes, then round FSM.
  always_comb begin
    state_d     = state_q;
    ack_d       = req_s_q;
    health_d    = health_q;
    iframe_d    = iframe_q;
    ko_cnt_d    = ko_cnt_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    draw_d      = draw_q;

    for (int i = 0; i < 2; i++) begin
      if (iframe_q[i] != '0) begin
        iframe_d[i] = iframe_q[i] - IFW'(1);
      end
      // Blocked hits (iframe or KO) are still acked so requesters never stall.
      if (hit_take[i] && (state_q == FIGHT) && (iframe_q[i] == '0)) begin
        health_d[i] = sat_sub(health_q[i], hit_damage(shielding_w[i], shield_w[i]));
        if (hit_damage(shielding_w[i], shield_w[i]) != '0) begin
          iframe_d[i] = IFW'(IFRAME_TICKS);
        end
      end
    end

    case (state_q)
      FIGHT: begin
        if ((health_d[0] == '0) || (health_d[1] == '0)) begin
          state_d     = KO;
          game_over_d = 1'b1;
          draw_d      = (health_d[0] == '0) && (health_d[1] == '0);
          winner_d    = (health_d[0] == '0) && (health_d[1] != '0);
          ko_cnt_d    = KOW'(KO_HOLD_TICKS);
        end
      end
      KO: begin
        if (ko_cnt_q != '0) begin
          ko_cnt_d = ko_cnt_q - KOW'(1);
        end else if (round_restart) begin
          state_d     = FIGHT;
          health_d    = {HW'(MAX_HEALTH), HW'(MAX_HEALTH)};
          iframe_d    = '0;
          game_over_d = 1'b0;
          winner_d    = 1'b0;
          draw_d      = 1'b0;
        end
      end
      default: begin
        state_d = FIGHT;
      end
    endcase
  end

  // State registers; synchronous active-low reset.
  always_ff @(posedge slowed_shield_clk) begin
    if (!reset) begin
      state_q      <= FIGHT;
      sync1_q      <= '0;
      req_s_q      <= '0;
      ack_q        <= '0;
      health_q     <= {HW'(MAX_HEALTH), HW'(MAX_HEALTH)};
      iframe_q     <= '0;
      iframe_act_q <= '0;
      ko_cnt_q     <= '0;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
      draw_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= {p1_hit_req, p0_hit_req};
      req_s_q      <= sync1_q;
      ack_q        <= ack_d;
      health_q     <= health_d;
      iframe_q     <= iframe_d;
      iframe_act_q <= {iframe_d[1] != '0, iframe_d[0] != '0};
      ko_cnt_q     <= ko_cnt_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
      draw_q       <= draw_d;
    end
  end

  assign hit_ack       = ack_q;
  assign p0_health     = health_q[0];
  assign p1_health     = health_q[1];
  assign iframe_active = iframe_act_q;
  assign game_over     = game_over_q;
  assign winner        = winner_q;
  assign draw          = draw_q;

endmodule

// File: tb/tb_health_resolver.sv
// Bench for health_resolver: directed round scenarios followed by random
// traffic, every output compared each tick against a behavioural model.
module tb_health_resolver;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] shd;
  logic [3:0] lvl0, lvl1;
  logic       restart;
  logic [1:0] hit_ack;
  logic [3:0] p0_health, p1_health;
  logic [1:0] iframe_active;
  logic       game_over, winner, draw;

  int checks = 0;
  int errors = 0;

  // Model state
  int m_h[2];
  int m_if[2];
  bit m_ack[2];
  bit m_ko, m_go, m_win, m_draw;
  int m_ko_left;
  bit seen1[2], seen2[2];

  health_resolver dut (
    .slowed_shield_clk(clk),
    .reset(rst_n),
    .p0_hit_req(req[0]),
    .p1_hit_req(req[1]),
    .p0_shielding(shd[0]),
    .p1_shielding(shd[1]),
    .p0_shield(lvl0),
    .p1_shield(lvl1),
    .round_restart(restart),
    .hit_ack(hit_ack),
    .p0_health(p0_health),
    .p1_health(p1_health),
    .iframe_active(iframe_active),
    .game_over(game_over),
    .winner(winner),
    .draw(draw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Request seen at edge k is acted on at edge k+2; ack simply mirrors that.
  task automatic model_edge();
    bit rs[2];
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_h[i] = 15; m_if[i] = 0; m_ack[i] = 0; seen1[i] = 0; seen2[i] = 0;
      end
      m_ko = 0; m_ko_left = 0; m_go = 0; m_win = 0; m_draw = 0;
      return;
    end
    for (int i = 0; i < 2; i++) rs[i] = seen2[i];
    for (int i = 0; i < 2; i++) begin
      int pre;
      int lvl;
      int dmg;
      pre = m_if[i];
      if (pre > 0) m_if[i] = pre - 1;
      if (rs[i] && !m_ack[i] && !m_ko && pre == 0) begin
        lvl = (i == 0) ? int'(lvl0) : int'(lvl1);
        dmg = (shd[i] && lvl >= 1) ? 1 : 3;
        m_h[i] = (m_h[i] > dmg) ? m_h[i] - dmg : 0;
        m_if[i] = 2;
      end
      m_ack[i] = rs[i];
    end
    if (!m_ko) begin
      if (m_h[0] == 0 || m_h[1] == 0) begin
        m_ko = 1; m_go = 1; m_ko_left = 6;
        m_draw = (m_h[0] == 0) && (m_h[1] == 0);
        m_win  = (m_h[0] == 0) && (m_h[1] != 0);
      end
    end else if (m_ko_left > 0) begin
      m_ko_left--;
    end else if (restart) begin
      m_ko = 0; m_go = 0; m_win = 0; m_draw = 0;
      for (int i = 0; i < 2; i++) begin m_h[i] = 15; m_if[i] = 0; end
    end
    for (int i = 0; i < 2; i++) begin
      seen2[i] = seen1[i];
      seen1[i] = req[i];
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("hit_ack", 8'(hit_ack), 8'({m_ack[1], m_ack[0]}));
    check("p0_health", 8'(p0_health), 8'(m_h[0]));
    check("p1_health", 8'(p1_health), 8'(m_h[1]));
    check("iframe_active", 8'(iframe_active), 8'({m_if[1] != 0, m_if[0] != 0}));
    check("game_over", 8'(game_over), 8'(m_go));
    check("winner", 8'(winner), 8'(m_win));
    check("draw", 8'(draw), 8'(m_draw));
  endtask

  // Full four-phase handshake for one player.
  task automatic hit(input int p);
    req[p] = 1'b1;
    for (int n = 0; n < 10 && !hit_ack[p]; n++) tick();
    check("hit_ack_rise", 8'(hit_ack[p]), 8'd1);
    req[p] = 1'b0;
    for (int n = 0; n < 10 && hit_ack[p]; n++) tick();
    check("hit_ack_fall", 8'(hit_ack[p]), 8'd0);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; req = '0; shd = '0; lvl0 = '0; lvl1 = '0; restart = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_p0", 8'(p0_health), 8'd15);
    check("rst_p1", 8'(p1_health), 8'd15);
    check("rst_ack", 8'(hit_ack), 8'd0);
    rst_n = 1'b1;
    tick();

    // Unshielded punch on p1, latency of three edges
    req[1] = 1'b1;
    cnt = 0;
    while (!hit_ack[1] && cnt < 10) begin tick(); cnt++; end
    check("ack_latency", 8'(cnt), 8'd3);
    check("p1_punch", 8'(p1_health), 8'd12);
    check("p1_iframe", 8'(iframe_active[1]), 8'd1);
    req[1] = 1'b0;
    cnt = 0;
    while (hit_ack[1] && cnt < 10) begin tick(); cnt++; end
    check("ack_clear_latency", 8'(cnt), 8'd3);
    tick(); tick();

    // Shielded chip, then unshielded punch on p0
    shd[0] = 1'b1; lvl0 = 4'd4;
    hit(0);
    check("p0_chip", 8'(p0_health), 8'd14);
    tick(); tick(); tick();
    lvl0 = 4'd0;
    hit(0);
    check("p0_zero_shield", 8'(p0_health), 8'd11);
    shd[0] = 1'b0;
    tick(); tick(); tick();

    // Second p1 hit while iframes still active is acked but blocked
    req[1] = 1'b1; tick();
    req[1] = 1'b0; tick();
    req[1] = 1'b1; tick();
    req[1] = 1'b0;
    repeat (6) tick();
    check("p1_iframe_block", 8'(p1_health), 8'd9);
    hit(1);
    check("p1_after_iframe", 8'(p1_health), 8'd6);
    tick(); tick(); tick();

    // Walk p0 to 2 and p1 to 3, then a simultaneous KO
    for (int n = 0; n < 8 && m_h[0] > 2; n++) begin hit(0); tick(); tick(); end
    for (int n = 0; n < 8 && m_h[1] > 3; n++) begin hit(1); tick(); tick(); end
    check("p0_pre_ko", 8'(p0_health), 8'd2);
    check("p1_pre_ko", 8'(p1_health), 8'd3);
    req = 2'b11;
    for (int n = 0; n < 10 && hit_ack != 2'b11; n++) tick();
    check("ko_game_over", 8'(game_over), 8'd1);
    check("ko_draw", 8'(draw), 8'd1);
    check("ko_winner", 8'(winner), 8'd0);
    check("ko_p0", 8'(p0_health), 8'd0);
    check("ko_p1", 8'(p1_health), 8'd0);

    // Restart held through KO hold; a hit during KO is acked harmlessly
    restart = 1'b1; req = 2'b00;
    cnt = 0;
    while (game_over && cnt < 20) begin
      if (cnt == 2) req[0] = 1'b1;
      tick();
      cnt++;
    end
    check("ko_hold_edges", 8'(cnt), 8'd7);
    check("restart_p0", 8'(p0_health), 8'd15);
    check("restart_p1", 8'(p1_health), 8'd15);
    check("ko_hit_acked", 8'(hit_ack[0]), 8'd1);
    restart = 1'b0; req = 2'b00;
    repeat (4) tick();

    // Single KO of p0, then reset while its ack is high
    for (int n = 0; n < 4; n++) begin hit(0); tick(); tick(); end
    req[0] = 1'b1;
    for (int n = 0; n < 10 && !hit_ack[0]; n++) tick();
    check("single_ko", 8'(game_over), 8'd1);
    check("single_ko_winner", 8'(winner), 8'd1);
    check("single_ko_draw", 8'(draw), 8'd0);
    rst_n = 1'b0;
    tick();
    check("midko_rst_ack", 8'(hit_ack), 8'd0);
    check("midko_rst_go", 8'(game_over), 8'd0);
    check("midko_rst_p0", 8'(p0_health), 8'd15);
    check("midko_rst_if", 8'(iframe_active), 8'd0);
    rst_n = 1'b1; req = 2'b00;
    repeat (4) tick();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rst_n   = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 2) == 0) req[0] = ~req[0];
      if ($urandom_range(0, 2) == 0) req[1] = ~req[1];
      shd     = 2'($urandom_range(0, 3));
      lvl0    = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      lvl1    = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      restart = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
